seq_div: RTL and testbench

- Multi-cycle iterative divider for the scheduled datapath; produces quotient and remainder of a / b.
- Results feed the datapath REG stage that captures operation outputs.
- Uses one restoring-division step per clock and a start/done handshake.
- Area-cheap alternative to the combinational DIV/MOD components when the schedule allows a multi-cycle latency.

---
 rtl/seq_div_pkg.sv | 18 +
 rtl/seq_div_step.sv | 25 ++
 rtl/seq_div.sv | 157 +++++++++++++++
 tb/tb_seq_div.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/seq_div_pkg.sv
// seq_div_pkg: shared state encoding and sizing helper for the iterative divider.
package seq_div_pkg;

  typedef logic [1:0] state_t;

  localparam state_t IDLE = 2'd0;
  localparam state_t CALC = 2'd1;
  localparam state_t DONE = 2'd2;

  // Bits needed to hold a step count of 0..v-1 (never less than one bit).
  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return (r < 1) ? 1 : r;
  endfunction

endpackage

// File: rtl/seq_div_step.sv
// div_step: one combinational restoring-division step.
// Shifts the next dividend bit into the partial remainder, trial-subtracts the
// divisor and keeps the difference when it is non-negative.
module div_step #(
  parameter int W = 32
) (
  input  logic [W:0]   pr_in,
  input  logic [W-1:0] dvs,
  input  logic         din,
  output logic [W:0]   pr_out,
  output logic         qbit
);

  logic [W+1:0] shifted;
  logic [W+1:0] trial;

  // Trial subtract one bit wider than the remainder so its sign is visible.
  always_comb begin
    shifted = {pr_in, din};
    trial   = shifted - {2'b00, dvs};
    qbit    = ~trial[W+1];
    pr_out  = qbit ? trial[W:0] : shifted[W:0];
  end

endmodule

// File: rtl/seq_div.sv
// seq_div: multi-cycle restoring divider, one quotient bit per clock.
// Start/done handshake; DATAWIDTH+1 edges from accepted start to done,
// divide-by-zero reports done two edges after start with dz set.
// Optional SEQ_DIV_SIGNED_EN: two's complement operands, quotient truncated
// toward zero, remainder takes the dividend's sign.
module seq_div
  import seq_div_pkg::*;
#(
  parameter int DATAWIDTH = 32
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 start,
  input  logic [DATAWIDTH-1:0] a,
  input  logic [DATAWIDTH-1:0] b,
  output logic [DATAWIDTH-1:0] quot,
  output logic [DATAWIDTH-1:0] rem,
  output logic                 busy,
  output logic                 done,
  output logic                 dz
);

  localparam int W  = DATAWIDTH;
  localparam int CW = clog2(DATAWIDTH);

  state_t        state;
  logic [CW-1:0] cnt;
  logic          steps_done;  // all W steps taken, next edge publishes result
  logic          zpend;       // divide-by-zero result still being published
  logic [W:0]    pr;          // partial remainder, one spare bit
  logic [W-1:0]  dvd;         // dividend shift register (MSB first)
  logic [W-1:0]  qr;          // quotient shift register
  logic [W-1:0]  dvs;         // latched divisor magnitude

  logic [W:0]    pr_nxt;
  logic          qbit;
  logic          accept;
  logic          b_zero;
  logic [W-1:0]  a_mag;
  logic [W-1:0]  b_mag;
  logic [W-1:0]  q_fin;
  logic [W-1:0]  r_fin;

`ifdef SEQ_DIV_SIGNED_EN
  logic neg_q;
  logic neg_r;
`endif

  div_step #(.W(W)) u_step (
    .pr_in  (pr),
    .dvs    (dvs),
    .din    (dvd[W-1]),
    .pr_out (pr_nxt),
    .qbit   (qbit)
  );

  // Start is only honoured once a previous result (if any) is on the outputs.
  always_comb begin
    accept = start && ((state == IDLE) || ((state == DONE) && done));
    b_zero = (b == '0);
  end

  // Operand magnitudes and final sign fix-up of the unsigned result.
  always_comb begin
`ifdef SEQ_DIV_SIGNED_EN
    a_mag = a[W-1] ? (~a + 1'b1) : a;
    b_mag = b[W-1] ? (~b + 1'b1) : b;
    q_fin = neg_q ? (~qr + 1'b1) : qr;
    r_fin = neg_r ? (~pr[W-1:0] + 1'b1) : pr[W-1:0];
`else
    a_mag = a;
    b_mag = b;
    q_fin = qr;
    r_fin = pr[W-1:0];
`endif
  end

  // FSM, step counter, datapath shift registers and output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      steps_done <= 1'b0;
      zpend      <= 1'b0;
      pr         <= '0;
      dvd        <= '0;
      qr         <= '0;
      dvs        <= '0;
      quot       <= '0;
      rem        <= '0;
      busy       <= 1'b0;
      done       <= 1'b0;
      dz         <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q      <= 1'b0;
      neg_r      <= 1'b0;
`endif
    end else if (accept) begin
      done       <= 1'b0;
      dz         <= 1'b0;
      busy       <= 1'b1;
      pr         <= '0;
      qr         <= '0;
      dvs        <= b_mag;
      cnt        <= CW'(W - 1);
      steps_done <= 1'b0;
`ifdef SEQ_DIV_SIGNED_EN
      neg_q      <= a[W-1] ^ b[W-1];
      neg_r      <= a[W-1];
`endif
      if (b_zero) begin
        // Raw dividend is kept so it can be returned as the remainder.
        dvd   <= a;
        zpend <= 1'b1;
        state <= DONE;
      end else begin
        dvd   <= a_mag;
        zpend <= 1'b0;
        state <= CALC;
      end
    end else begin
      case (state)
        CALC: begin
          if (!steps_done) begin
            pr  <= pr_nxt;
            qr  <= {qr[W-2:0], qbit};
            dvd <= {dvd[W-2:0], 1'b0};
            if (cnt == '0) steps_done <= 1'b1;
            else           cnt        <= cnt - 1'b1;
          end else begin
            state <= DONE;
            busy  <= 1'b0;
            done  <= 1'b1;
            quot  <= q_fin;
            rem   <= r_fin;
          end
        end
        DONE: begin
          // Divide-by-zero: one busy cycle, then one setup cycle, then done.
          if (zpend) begin
            if (busy) begin
              busy <= 1'b0;
            end else begin
              done  <= 1'b1;
              dz    <= 1'b1;
              quot  <= '1;
              rem   <= dvd;
              zpend <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_seq_div.sv
// tb_seq_div: randomized scoreboard bench for seq_div at DATAWIDTH=8.
// Stimulus pushes model results into a queue; a monitor pops on each rising done.
module tb_seq_div;

  localparam int W = 8;

  typedef struct packed {
    logic [W-1:0] q;
    logic [W-1:0] r;
    logic         z;
  } exp_t;

  logic         clk;
  logic         rst;
  logic         start;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic [W-1:0] quot;
  logic [W-1:0] rem;
  logic         busy;
  logic         done;
  logic         dz;

  int   total;
  int   bad;
  exp_t exp_q[$];
  logic done_q;

  seq_div #(.DATAWIDTH(W)) dut (
    .clk   (clk),
    .rst   (rst),
    .start (start),
    .a     (a),
    .b     (b),
    .quot  (quot),
    .rem   (rem),
    .busy  (busy),
    .done  (done),
    .dz    (dz)
  );

  // clk_gen
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain language arithmetic on the operand values.
  function automatic exp_t model(input logic [W-1:0] x, input logic [W-1:0] y);
    exp_t e;
    int   sx, sy, iq, ir;
    if (y == '0) begin
      e.q = '1;
      e.r = x;
      e.z = 1'b1;
      return e;
    end
`ifdef SEQ_DIV_SIGNED_EN
    sx = int'($signed(x));
    sy = int'($signed(y));
`else
    sx = int'(x);
    sy = int'(y);
`endif
    iq  = sx / sy;
    ir  = sx % sy;
    e.q = iq[W-1:0];
    e.r = ir[W-1:0];
    e.z = 1'b0;
    return e;
  endfunction

  task automatic check(input string name, input bit ok, input int act, input int req);
    total++;
    if (!ok) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // Monitor: compare the presented result on every rising edge of done.
  always @(negedge clk) begin
    if (!rst && done && !done_q) begin
      if (exp_q.size() == 0) begin
        check("unexpected_done", 1'b0, 1, 0);
      end else begin
        exp_t e;
        e = exp_q.pop_front();
        check("sb_quot", quot == e.q, int'(quot), int'(e.q));
        check("sb_rem",  rem  == e.r, int'(rem),  int'(e.r));
        check("sb_dz",   dz   == e.z, int'(dz),   int'(e.z));
      end
    end
    done_q <= done;
  end

  // One division: start for one cycle, check acceptance and latency.
  task automatic run_div(input logic [W-1:0] ta, input logic [W-1:0] tb_v);
    int lat;
    @(negedge clk);
    start = 1'b1;
    a     = ta;
    b     = tb_v;
    exp_q.push_back(model(ta, tb_v));
    @(posedge clk); #1;
    start = 1'b0;
    check("accept_busy", busy == 1'b1 && done == 1'b0, int'(busy), 1);
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("latency", lat == ((tb_v == '0) ? 2 : W + 1), lat, (tb_v == '0) ? 2 : W + 1);
  endtask

  initial begin
    exp_t e;
    int   lat;
    bit   no_done;
    total  = 0;
    bad    = 0;
    done_q = 1'b0;
    start  = 1'b0;
    a      = '0;
    b      = '0;

    // rst_gen: reset held with a pending start; outputs must stay cleared.
    rst   = 1'b1;
    start = 1'b1;
    a     = 8'd200;
    b     = 8'd3;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      check("reset_outs", busy == 0 && done == 0 && quot == 0 && rem == 0 && dz == 0,
            int'({busy, done, dz}), 0);
    end
    @(negedge clk);
    rst   = 1'b0;
    start = 1'b0;

    // Basic division and result hold.
    run_div(8'd200, 8'd7);
    e = model(8'd200, 8'd7);
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("hold_quot", done == 1'b1 && quot == e.q && rem == e.r, int'(quot), int'(e.q));
    end

    // Divide by zero.
    run_div(8'd55, 8'd0);

    // Start mid-CALC is ignored.
    @(negedge clk);
    start = 1'b1; a = 8'd9; b = 8'd2;
    exp_q.push_back(model(8'd9, 8'd2));
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk); start = 1'b1; a = 8'd100; b = 8'd10;
    @(negedge clk); start = 1'b0;
    lat = 0;
    while (!done && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    check("ignore_done_seen", done == 1'b1, int'(done), 1);
    repeat (12) @(posedge clk);
    #1;
    e = model(8'd9, 8'd2);
    check("ignore_no_rerun", done == 1'b1 && busy == 1'b0 && quot == e.q, int'(quot), int'(e.q));

    // Start held high: back-to-back runs, one done cycle between them.
    @(negedge clk);
    start = 1'b1; a = 8'd255; b = 8'd1;
    for (int n = 0; n < 3; n++) exp_q.push_back(model(8'd255, 8'd1));
    @(posedge clk); #1;
    for (int n = 0; n < 3; n++) begin
      lat = 0;
      while (!done && lat < 40) begin
        @(posedge clk); #1;
        lat++;
      end
      check("b2b_latency", lat == W + 1, lat, W + 1);
      if (n == 2) start = 1'b0;
      @(posedge clk); #1;
      if (n < 2) check("b2b_done_one_cycle", done == 1'b0 && busy == 1'b1, int'(done), 0);
    end

    // Reset in the middle of a division.
    @(negedge clk);
    start = 1'b1; a = 8'd100; b = 8'd3;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk); rst = 1'b1;
    @(posedge clk); #1;
    check("midop_reset", busy == 0 && done == 0 && quot == 0 && rem == 0 && dz == 0,
          int'({busy, done, dz}), 0);
    @(negedge clk); rst = 1'b0;
    no_done = 1'b1;
    for (int i = 0; i < 15; i++) begin
      @(posedge clk); #1;
      if (done || busy) no_done = 1'b0;
    end
    check("midop_no_done", no_done, int'(no_done), 1);

    // Corner operands, then a random sweep.
    for (int i = 0; i < 4; i++) begin
      for (int j = 0; j < 4; j++) begin
        logic [W-1:0] ca, cb;
        ca = (i == 0) ? 8'd0 : (i == 1) ? 8'd1 : (i == 2) ? 8'd128 : 8'd255;
        cb = (j == 0) ? 8'd0 : (j == 1) ? 8'd1 : (j == 2) ? 8'd128 : 8'd255;
        run_div(ca, cb);
      end
    end
`ifdef SEQ_DIV_SIGNED_EN
    run_div(8'hF9, 8'd2);
    run_div(8'h80, 8'hFF);
`endif
    for (int i = 0; i < 1500; i++) begin
      logic [W-1:0] ra, rb;
      ra = W'($urandom_range(0, 255));
      rb = (i % 16 == 0) ? 8'd0 : W'($urandom_range(0, 255));
      run_div(ra, rb);
    end

    repeat (3) @(posedge clk);
    #1;
    check("queue_drained", exp_q.size() == 0, exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
